// File: rtl/count_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// A start/done handshake delivers one stable packed-BCD result per conversion.
module count_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adjusted;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  // Add-3 correction: digits are always <= 9 here, so a 4-bit add never carries out.
  always_comb begin
    adjusted = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bit_cnt_d = bit_cnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          bit_cnt_d = '0;
          state_d   = CONV;
        end else begin
          state_d   = IDLE;
        end
      end
      CONV: begin
        scratch_d = {adjusted[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bcd_d   = {adjusted[BCD_W-2:0], shift_q[WIDTH-1]};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      bit_cnt_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bit_cnt_q <= bit_cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;

endmodule
